// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared constants, state type and command packing for the tour replayer
package tour_pkg;

  // Command opcodes
  localparam logic [3:0] OP_MOVE         = 4'h2;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;

  // Robot headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // Response bytes
  localparam logic [7:0] ACK_DONE = 8'hA5;
  localparam logic [7:0] ACK_POS  = 8'h5A;

  // Bit index of each knight move in the one-hot move byte, named by (dx,dy)
  localparam int MV_P1_P2 = 0;  // (+1,+2)
  localparam int MV_M1_P2 = 1;  // (-1,+2)
  localparam int MV_M2_P1 = 2;  // (-2,+1)
  localparam int MV_M2_M1 = 3;  // (-2,-1)
  localparam int MV_M1_M2 = 4;  // (-1,-2)
  localparam int MV_P1_M2 = 5;  // (+1,-2)
  localparam int MV_P2_M1 = 6;  // (+2,-1)
  localparam int MV_P2_P1 = 7;  // (+2,+1)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_HOLDV,
    ST_HORZ,
    ST_HOLDH
  } state_t;

  // Pack a command word as {opcode, heading, squares}
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// rtl/tour_move_decode.sv - split a one-hot knight move into vertical and horizontal commands
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o
);

  logic [7:0] v_hdg, h_hdg;
  logic [3:0] v_sq, h_sq;

  // Leg heading/length per move; anything not exactly one-hot becomes a zero-length north move
  always_comb begin
    v_hdg = HDG_N;
    v_sq  = 4'd0;
    h_hdg = HDG_N;
    h_sq  = 4'd0;
    case (move_i)
      8'(1 << MV_P1_P2): begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
      8'(1 << MV_M1_P2): begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
      8'(1 << MV_M2_P1): begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
      8'(1 << MV_M2_M1): begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
      8'(1 << MV_M1_M2): begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
      8'(1 << MV_P1_M2): begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
      8'(1 << MV_P2_M1): begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
      8'(1 << MV_P2_P1): begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
      default: ;
    endcase
  end

  assign vert_cmd_o = mk_cmd(OP_MOVE, v_hdg, v_sq);
  assign horz_cmd_o = mk_cmd(OP_MOVE_FANFARE, h_hdg, h_sq);

endmodule

// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - replays stored knight moves as vertical/horizontal robot commands, UART mux when idle
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;
  logic [15:0] vert_cmd, horz_cmd;

  tour_move_decode u_decode (
    .move_i     (move),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd)
  );

  // State and move index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next state, index update and command/response muxing
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    cmd       = cmd_UART;
    cmd_rdy   = cmd_rdy_UART;
    resp      = ACK_POS;
    unique case (state_q)
      ST_IDLE: begin
        resp = ACK_DONE;
        if (start_tour) begin
          mv_indx_d = 5'd0;
          state_d   = ST_VERT;
        end
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        // A send_resp arriving with clr is dropped; only the accept counts here
        if (clr_cmd_rdy) state_d = ST_HOLDV;
      end
      ST_HOLDV: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b0;
        if (send_resp) state_d = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = ST_HOLDH;
      end
      ST_HOLDH: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b0;
        if (mv_indx_q == LAST_IDX) begin
          resp = ACK_DONE;
          if (send_resp) state_d = ST_IDLE;
        end else if (send_resp) begin
          mv_indx_d = mv_indx_q + 5'd1;
          state_d   = ST_VERT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mv_indx = mv_indx_q;

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Consumer/reader side of the tour solver's move store: walks stored knight moves by driving `mv_indx` and reading back the 8-bit one-hot `move`.
- Each knight move is split into two robot commands: vertical leg first, then horizontal leg.
- Commands are presented to the command processor with a ready/clear/response handshake.
- Outside a tour, the block is a transparent mux passing UART-originated commands and ready through unchanged.

Parameters:
- NUM_MOVES, 24, number of stored moves replayed per tour (5x5 board, 25 squares).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start_tour  input  1  single-cycle pulse; begins replay from index 0.
- move  input  8  one-hot move read from the solver at mv_indx.
- mv_indx  output  5  index into the solver move store.
- cmd_UART  input  16  command from UART wrapper.
- cmd_rdy_UART  input  1  UART command valid.
- cmd  output  16  command to command processor.
- cmd_rdy  output  1  cmd valid.
- clr_cmd_rdy  input  1  processor has accepted cmd.
- send_resp  input  1  processor finished executing cmd.
- resp  output  8  response byte to UART transmitter.

Behaviour:
- Move encoding (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- cmd format: [15:12] opcode, [11:4] heading, [3:0] squares.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Vertical leg:
  - opcode 4'h2 (move), heading N if dy>0 else S, squares |dy|.
- Horizontal leg:
  - opcode 4'h3 (move with fanfare), heading E if dx>0 else W, squares |dx|.
- Non-one-hot move (including 8'h00):
  - both legs emit squares=0, heading N, with the normal opcode.
  - Handshake still proceeds.
- States: IDLE, VERT, HOLDV, HORZ, HOLDH.
- Reset (async): state=IDLE, mv_indx=0.
  - Outputs are then cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- IDLE:
  - Mux selects UART path (combinational pass-through, 0-cycle latency).
  - start_tour: mv_indx<=0, next=VERT.
- VERT:
  - cmd = vertical leg of move, cmd_rdy=1.
  - clr_cmd_rdy: next=HOLDV.
- HOLDV:
  - cmd held, cmd_rdy=0.
  - send_resp: next=HORZ.
- HORZ:
  - cmd = horizontal leg, cmd_rdy=1.
  - clr_cmd_rdy: next=HOLDH.
- HOLDH:
  - cmd held, cmd_rdy=0.
  - send_resp at mv_indx==NUM_MOVES-1: next=IDLE.
  - Otherwise send_resp: mv_indx<=mv_indx+1, next=VERT.
- resp:
  - 8'hA5 in IDLE, and in HOLDH when mv_indx==NUM_MOVES-1.
  - 8'h5A otherwise.
- mv_indx:
  - Only changes on the transitions above; never exceeds NUM_MOVES-1.
  - Stays at last value after the tour until the next start_tour.
- Boundary conditions:
  - start_tour outside IDLE is ignored.
  - clr_cmd_rdy in HOLDV/HOLDH is ignored.
  - send_resp in VERT/HORZ is ignored.
  - clr_cmd_rdy and send_resp together in VERT/HORZ: only clr acts; the send_resp is dropped.
  - cmd_rdy_UART during a tour is ignored (not forwarded).
  - Reset mid-tour returns to IDLE with mv_indx=0 immediately.
- All state is registered. cmd, cmd_rdy and resp are combinational from state, move and UART inputs.

Decomposition:
- Package tour_pkg:
  - opcode constants (MOVE=4'h2, MOVE_FANFARE=4'h3)
  - heading constants
  - response constants (ACK_DONE=8'hA5, ACK_POS=8'h5A)
  - move bit-index constants
  - state enum typedef
- Sub-module tour_move_decode (combinational): move -> {vert_cmd, horz_cmd}. Unit-testable standalone.

Test Plan:
- Reset, idle: cmd_UART=16'h1234, cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, resp=8'hA5; start_tour=0.
- start_tour, move=8'h01:
  - VERT: cmd=16'h2002, cmd_rdy=1.
  - clr_cmd_rdy: cmd_rdy=0.
  - send_resp: cmd=16'h3BF1, cmd_rdy=1.
  - After full handshake: mv_indx=1, resp=8'h5A.
- move=8'h08 -> vertical 16'h27F1, horizontal 16'h33F2. Repeat for all 8 bits against the table.
- Full 24-move replay with a processor model:
  - mv_indx walks 0..23, 48 commands issued.
  - resp=8'hA5 during the final HOLDH.
  - Return to IDLE; mv_indx holds 23.
- Simultaneous clr_cmd_rdy and send_resp in VERT -> HOLDV, no advance to HORZ until a later send_resp.
- Second start_tour mid-tour is ignored.
- rst_n low in HORZ -> async IDLE, mv_indx=0, UART pass-through restored the same cycle.
